// File: rtl/cache_tag_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : cache_tag_pkg
//  Description: Shared widths, address field positions, controller state
//               encoding and a one-hot helper for the way-halting tag
//               lookup controller.
//  Revision   : 1.0 - initial release
// ============================================================================
package cache_tag_pkg;

    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 8;
    localparam int SET_W    = $clog2(NUM_SETS);
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int HALT_W   = 4;
    localparam int MAIN_W   = 20;
    localparam int ADDR_W   = 32;

    // Address layout: [31:12] main tag, [11:8] halt tag, [7:5] set, [4:0] offset
    localparam int SET_LSB  = 5;
    localparam int HALT_LSB = 8;
    localparam int MAIN_LSB = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        MAIN  = 3'd2,
        MISS  = 3'd3,
        WRITE = 3'd4
    } state_t;

    // Isolate the lowest set bit (two's-complement trick); zero in -> zero out.
    function automatic logic [NUM_WAYS-1:0] lowest_one_hot(input logic [NUM_WAYS-1:0] v);
        return v & (~v + NUM_WAYS'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tag_lookup_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface  : tag_lookup_ctrl_if
//  Description: Front-end request/response, refill handshake and tag-array
//               read/write bundle for tag_lookup_ctrl. The controller uses
//               the slave modport; the surrounding system uses master.
//  Revision   : 1.0 - initial release
// ============================================================================
interface tag_lookup_ctrl_if;
    import cache_tag_pkg::*;

    logic                       req_valid;
    logic [ADDR_W-1:0]          req_addr;
    logic                       req_ready;
    logic                       inv_all;
    logic [SET_W-1:0]           tag_set;
    logic [NUM_WAYS*HALT_W-1:0] halt_tag_rd;
    logic [NUM_WAYS-1:0]        main_rd_en;
    logic [NUM_WAYS*MAIN_W-1:0] main_tag_rd;
    logic                       refill_req;
    logic                       refill_ack;
    logic                       tag_wr;
    logic [NUM_WAYS-1:0]        tag_wr_way;
    logic [HALT_W-1:0]          wr_halt_tag;
    logic [MAIN_W-1:0]          wr_main_tag;
    logic                       resp_valid;
    logic                       resp_hit;
    logic [NUM_WAYS-1:0]        resp_way;

    modport master (
        output req_valid, req_addr, inv_all, halt_tag_rd, main_tag_rd, refill_ack,
        input  req_ready, tag_set, main_rd_en, refill_req, tag_wr, tag_wr_way,
               wr_halt_tag, wr_main_tag, resp_valid, resp_hit, resp_way
    );

    modport slave (
        input  req_valid, req_addr, inv_all, halt_tag_rd, main_tag_rd, refill_ack,
        output req_ready, tag_set, main_rd_en, refill_req, tag_wr, tag_wr_way,
               wr_halt_tag, wr_main_tag, resp_valid, resp_hit, resp_way
    );

endinterface
`default_nettype wire

// File: rtl/tag_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module     : tag_victim_sel
//  Description: Refill victim choice for one set. The lowest invalid way
//               wins; when the set is full the round-robin pointer picks the
//               way and the pointer advances.
//  Revision   : 1.0 - initial release
// ============================================================================
module tag_victim_sel
    import cache_tag_pkg::*;
(
    input  wire logic [NUM_WAYS-1:0] valid,
    input  wire logic [WAY_W-1:0]    rr_ptr,
    output logic      [NUM_WAYS-1:0] victim,
    output logic                     from_ptr,
    output logic      [WAY_W-1:0]    next_ptr
);

    // Prefer an empty way; fall back to the pointer only for a full set.
    always_comb begin
        from_ptr = &valid;
        victim   = from_ptr ? (NUM_WAYS'(1) << rr_ptr) : lowest_one_hot(~valid);
        next_ptr = (rr_ptr == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_ptr + WAY_W'(1);
    end

endmodule
`default_nettype wire

// File: rtl/tag_lookup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tag_lookup_ctrl
//  Description: Lookup/refill/invalidate sequencer for a way-halting tag
//               store. Halt tags gate the main-tag compare; misses run the
//               refill handshake and write the chosen victim way.
//  Options    : TAG_CTRL_STATS_EN adds saturating hit/miss/early-miss
//               counters as extra output ports.
//  Revision   : 1.0 - initial release
// ============================================================================
module tag_lookup_ctrl
    import cache_tag_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    tag_lookup_ctrl_if.slave bus
`ifdef TAG_CTRL_STATS_EN
    ,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_misses,
    output logic [31:0]      stat_early_miss
`endif
);

    state_t                             r_state, w_state_n;
    logic [SET_W-1:0]                   r_set, w_set_n;
    logic [HALT_W-1:0]                  r_halt, w_halt_n;
    logic [MAIN_W-1:0]                  r_main, w_main_n;
    logic [NUM_WAYS-1:0]                r_main_rd_en, w_main_rd_en_n;
    logic                               r_refill_req, w_refill_req_n;
    logic                               r_tag_wr, w_tag_wr_n;
    logic [NUM_WAYS-1:0]                r_tag_wr_way, w_tag_wr_way_n;
    logic [HALT_W-1:0]                  r_wr_halt, w_wr_halt_n;
    logic [MAIN_W-1:0]                  r_wr_main, w_wr_main_n;
    logic                               r_resp_valid, w_resp_valid_n;
    logic                               r_resp_hit, w_resp_hit_n;
    logic [NUM_WAYS-1:0]                r_resp_way, w_resp_way_n;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0]  r_valid;
    logic [NUM_SETS-1:0][WAY_W-1:0]     r_rr;

    logic [NUM_WAYS-1:0]                w_hm;
    logic [NUM_WAYS-1:0]                w_main_hit;
    logic [NUM_WAYS-1:0]                w_victim;
    logic                               w_from_ptr;
    logic [WAY_W-1:0]                   w_next_ptr;
    logic                               w_inv_clr;
    logic                               unused_offset;

    // Line offset plays no part in tag lookup.
    assign unused_offset = ^bus.req_addr[SET_LSB-1:0];

    assign w_inv_clr     = (r_state == IDLE) && bus.inv_all;
    assign bus.req_ready = (r_state == IDLE) && !bus.inv_all;

    // Per-way halt match (HALT) and main-tag match restricted to enabled ways (MAIN).
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign w_hm[w]       = r_valid[r_set][w] &&
                               (bus.halt_tag_rd[w*HALT_W +: HALT_W] == r_halt);
        assign w_main_hit[w] = r_main_rd_en[w] &&
                               (bus.main_tag_rd[w*MAIN_W +: MAIN_W] == r_main);
    end

    tag_victim_sel u_victim_sel (
        .valid    (r_valid[r_set]),
        .rr_ptr   (r_rr[r_set]),
        .victim   (w_victim),
        .from_ptr (w_from_ptr),
        .next_ptr (w_next_ptr)
    );

    // Next state and next values of every registered output.
    always_comb begin
        w_state_n      = r_state;
        w_set_n        = r_set;
        w_halt_n       = r_halt;
        w_main_n       = r_main;
        w_main_rd_en_n = '0;
        w_refill_req_n = 1'b0;
        w_tag_wr_n     = 1'b0;
        w_tag_wr_way_n = '0;
        w_wr_halt_n    = '0;
        w_wr_main_n    = '0;
        w_resp_valid_n = 1'b0;
        w_resp_hit_n   = 1'b0;
        w_resp_way_n   = '0;
        case (r_state)
            IDLE: begin
                if (!bus.inv_all && bus.req_valid) begin
                    w_set_n   = bus.req_addr[SET_LSB  +: SET_W];
                    w_halt_n  = bus.req_addr[HALT_LSB +: HALT_W];
                    w_main_n  = bus.req_addr[MAIN_LSB +: MAIN_W];
                    w_state_n = HALT;
                end
            end
            HALT: begin
                if (w_hm == '0) begin
                    w_refill_req_n = 1'b1;
                    w_state_n      = MISS;
                end else begin
                    w_main_rd_en_n = w_hm;
                    w_state_n      = MAIN;
                end
            end
            MAIN: begin
                if (|w_main_hit) begin
                    w_resp_valid_n = 1'b1;
                    w_resp_hit_n   = 1'b1;
                    w_resp_way_n   = lowest_one_hot(w_main_hit);
                    w_state_n      = IDLE;
                end else begin
                    w_refill_req_n = 1'b1;
                    w_state_n      = MISS;
                end
            end
            MISS: begin
                if (bus.refill_ack) begin
                    w_tag_wr_n     = 1'b1;
                    w_tag_wr_way_n = w_victim;
                    w_wr_halt_n    = r_halt;
                    w_wr_main_n    = r_main;
                    w_resp_valid_n = 1'b1;
                    w_resp_way_n   = w_victim;
                    w_state_n      = WRITE;
                end else begin
                    w_refill_req_n = 1'b1;
                end
            end
            WRITE:   w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_set        <= '0;
            r_halt       <= '0;
            r_main       <= '0;
            r_main_rd_en <= '0;
            r_refill_req <= 1'b0;
            r_tag_wr     <= 1'b0;
            r_tag_wr_way <= '0;
            r_wr_halt    <= '0;
            r_wr_main    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
        end else begin
            r_state      <= w_state_n;
            r_set        <= w_set_n;
            r_halt       <= w_halt_n;
            r_main       <= w_main_n;
            r_main_rd_en <= w_main_rd_en_n;
            r_refill_req <= w_refill_req_n;
            r_tag_wr     <= w_tag_wr_n;
            r_tag_wr_way <= w_tag_wr_way_n;
            r_wr_halt    <= w_wr_halt_n;
            r_wr_main    <= w_wr_main_n;
            r_resp_valid <= w_resp_valid_n;
            r_resp_hit   <= w_resp_hit_n;
            r_resp_way   <= w_resp_way_n;
        end
    end

    // Valid bits and RR pointers commit at the end of WRITE, so the victim
    // seen during WRITE is the one chosen on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_rr    <= '0;
        end else if (w_inv_clr) begin
            r_valid <= '0;
        end else if (r_state == WRITE) begin
            r_valid[r_set] <= r_valid[r_set] | w_victim;
            if (w_from_ptr) begin
                r_rr[r_set] <= w_next_ptr;
            end
        end
    end

    assign bus.tag_set     = r_set;
    assign bus.main_rd_en  = r_main_rd_en;
    assign bus.refill_req  = r_refill_req;
    assign bus.tag_wr      = r_tag_wr;
    assign bus.tag_wr_way  = r_tag_wr_way;
    assign bus.wr_halt_tag = r_wr_halt;
    assign bus.wr_main_tag = r_wr_main;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_hit    = r_resp_hit;
    assign bus.resp_way    = r_resp_way;

`ifdef TAG_CTRL_STATS_EN
    logic w_hit_ev, w_early_ev, w_miss_ev;

    assign w_hit_ev   = (r_state == MAIN) && (|w_main_hit);
    assign w_early_ev = (r_state == HALT) && (w_hm == '0);
    assign w_miss_ev  = w_early_ev || ((r_state == MAIN) && !(|w_main_hit));

    // Saturating event counters, cleared alongside the valid bits.
    always_ff @(posedge clk) begin
        if (reset || w_inv_clr) begin
            stat_hits       <= '0;
            stat_misses     <= '0;
            stat_early_miss <= '0;
        end else begin
            if (w_hit_ev && (stat_hits != '1))
                stat_hits <= stat_hits + 32'd1;
            if (w_miss_ev && (stat_misses != '1))
                stat_misses <= stat_misses + 32'd1;
            if (w_early_ev && (stat_early_miss != '1))
                stat_early_miss <= stat_early_miss + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
